// File: rtl/date_set_ctrl.sv
// Front-panel edit controller for the day-of-month counter: fetches the running
// date, lets the operator step it up/down, and writes it back with a load pulse.
module date_set_ctrl #(
    parameter int DAY_MAX     = 29,
    parameter int BLINK_DIV   = 25_000_000,
    parameter int TIMEOUT_CYC = 500_000_000
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [4:0] databus,
    output logic       rd_en,
    output logic       load,
    output logic [4:0] data,
    output logic       editing,
    output logic       blink
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [4:0]    DMAX       = 5'(DAY_MAX);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] EDIT   = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    logic [1:0]    state, state_n;
    logic [4:0]    shadow, shadow_n;
    logic [TW-1:0] to_cnt, to_n;
    logic [BW-1:0] blink_cnt, blink_cnt_n;
    logic          blink_n;
    logic          mode_q, up_q, down_q;
    logic          mode_ev, up_ev, down_ev;

    assign mode_ev = btn_mode & ~mode_q;
    assign up_ev   = btn_up   & ~up_q;
    assign down_ev = btn_down & ~down_q;

    // Next-state logic; every output is registered from these next values so
    // nothing reaches the ports combinationally from the buttons.
    always_comb begin
        state_n     = state;
        shadow_n    = shadow;
        to_n        = to_cnt;
        blink_cnt_n = blink_cnt;
        blink_n     = 1'b0;
        case (state)
            IDLE: begin
                if (mode_ev) state_n = FETCH;
            end
            FETCH: begin
                state_n     = EDIT;
                shadow_n    = (databus > DMAX) ? 5'd0 : databus;
                to_n        = '0;
                blink_cnt_n = '0;
                blink_n     = 1'b1;
            end
            EDIT: begin
                to_n = to_cnt + 1'b1;
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt_n = '0;
                    blink_n     = ~blink;
                end else begin
                    blink_cnt_n = blink_cnt + 1'b1;
                    blink_n     = blink;
                end
                // Mode wins over a coincident step; up+down together cancel out.
                if (mode_ev) begin
                    state_n = COMMIT;
                end else if (up_ev ^ down_ev) begin
                    if (up_ev) shadow_n = (shadow == DMAX) ? 5'd0 : shadow + 5'd1;
                    else       shadow_n = (shadow == 5'd0) ? DMAX : shadow - 5'd1;
                    to_n        = '0;
                    blink_cnt_n = '0;
                    blink_n     = 1'b1;
                end else if (to_cnt == TO_LAST) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (state_n != EDIT) blink_n = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= IDLE;
            shadow    <= 5'd0;
            to_cnt    <= '0;
            blink_cnt <= '0;
            mode_q    <= 1'b0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            rd_en     <= 1'b0;
            load      <= 1'b0;
            data      <= 5'd0;
            editing   <= 1'b0;
            blink     <= 1'b0;
        end else begin
            state     <= state_n;
            shadow    <= shadow_n;
            to_cnt    <= to_n;
            blink_cnt <= blink_cnt_n;
            mode_q    <= btn_mode;
            up_q      <= btn_up;
            down_q    <= btn_down;
            rd_en     <= (state_n == FETCH);
            load      <= (state_n == COMMIT);
            data      <= (state_n == COMMIT) ? shadow : 5'd0;
            editing   <= (state_n == FETCH) || (state_n == EDIT);
            blink     <= blink_n;
        end
    end

endmodule

// File: tb/tb_date_set_ctrl.sv
// Directed bench for date_set_ctrl: committed values go through a scoreboard
// queue that is drained whenever the DUT pulses load.
module tb_date_set_ctrl;

    logic       clk = 1'b0;
    logic       clear;
    logic       btn_mode, btn_up, btn_down;
    logic [4:0] databus;
    logic       rd_en, load, editing, blink;
    logic [4:0] data;
    logic [4:0] day_cnt;

    int checks = 0;
    int passed = 0;
    logic [4:0] sb_q[$];

    date_set_ctrl #(
        .DAY_MAX    (29),
        .BLINK_DIV  (4),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk     (clk),
        .clear   (clear),
        .btn_mode(btn_mode),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .databus (databus),
        .rd_en   (rd_en),
        .load    (load),
        .data    (data),
        .editing (editing),
        .blink   (blink)
    );

    always #5 clk = ~clk;

    // Stand-in for the attached day counter: loads on load, otherwise advances 0..29.
    always @(posedge clk) begin
        if (load) day_cnt <= data;
        else      day_cnt <= (day_cnt == 5'd29) ? 5'd0 : day_cnt + 5'd1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic m, input logic u, input logic d, input int n);
        btn_mode = m;
        btn_up   = u;
        btn_down = d;
        tick(n);
    endtask

    task automatic pressUp();
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
    endtask

    task automatic pressDown();
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
    endtask

    task automatic enterEdit(input logic [4:0] v);
        databus = v;
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("fetch_rd_en", rd_en, 1);
        checkOutput("fetch_editing", editing, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("edit_rd_en_low", rd_en, 0);
        checkOutput("edit_blink_entry", blink, 1);
    endtask

    task automatic commitEdit(input logic [4:0] expv);
        sb_q.push_back(expv);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("commit_load", load, 1);
        checkOutput("commit_editing", editing, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("commit_load_low", load, 0);
    endtask

    // Scoreboard drain, sampled mid-cycle so outputs are settled.
    always @(negedge clk) begin
        if (load) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_load", load, 0);
            end else begin
                checkOutput("load_data", data, sb_q.pop_front());
                checkOutput("load_rd_excl", rd_en, 0);
            end
        end
    end

    initial begin
        clear    = 1'b1;
        btn_mode = 1'b1;
        btn_up   = 1'b1;
        btn_down = 1'b1;
        databus  = 5'd5;
        tick(2);
        checkOutput("rst_rd_en", rd_en, 0);
        checkOutput("rst_load", load, 0);
        checkOutput("rst_data", data, 0);
        checkOutput("rst_editing", editing, 0);
        checkOutput("rst_blink", blink, 0);

        // Buttons held through clear fire once after release.
        clear = 1'b0;
        tick(1);
        checkOutput("held_fetch_rd_en", rd_en, 1);
        tick(1);
        checkOutput("held_single_fetch", rd_en, 0);
        checkOutput("held_edit", editing, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(1);
        checkOutput("held_cleared", editing, 0);

        day_cnt = 5'd0;
        enterEdit(5'd12);
        pressUp();
        pressUp();
        pressUp();
        commitEdit(5'd15);
        checkOutput("counter_loaded", day_cnt, 15);
        tick(1);
        checkOutput("counter_next", day_cnt, 16);

        enterEdit(5'd29);
        pressUp();
        commitEdit(5'd0);
        enterEdit(5'd0);
        pressDown();
        commitEdit(5'd29);
        enterEdit(5'd30);
        commitEdit(5'd0);

        enterEdit(5'd10);
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        commitEdit(5'd10);

        // Coincident up+down must not postpone the timeout.
        enterEdit(5'd20);
        tick(8);
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 6);
        checkOutput("updown_still_edit", editing, 1);
        tick(1);
        checkOutput("updown_timeout", editing, 0);

        enterEdit(5'd7);
        pressUp();
        sb_q.push_back(5'd8);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkOutput("mode_up_load", load, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);

        enterEdit(5'd3);
        tick(15);
        checkOutput("to_still_edit", editing, 1);
        tick(1);
        checkOutput("to_idle", editing, 0);
        checkOutput("to_no_load", load, 0);

        enterEdit(5'd3);
        tick(10);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 15);
        checkOutput("to_press_still_edit", editing, 1);
        tick(1);
        checkOutput("to_press_idle", editing, 0);

        enterEdit(5'd5);
        pressUp();
        pressUp();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        checkOutput("clr_editing", editing, 0);
        checkOutput("clr_load", load, 0);
        checkOutput("clr_blink", blink, 0);
        tick(2);
        checkOutput("clr_no_load_after", load, 0);

        enterEdit(5'd9);
        for (int i = 0; i < 6; i++) begin
            checkOutput("blink_pattern", blink, (i < 4) ? 1 : 0);
            tick(1);
        end
        checkOutput("blink_low_phase", blink, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        btn_up = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checkOutput("blink_restart", blink, (i < 4) ? 1 : 0);
            tick(1);
        end
        commitEdit(5'd10);
        checkOutput("blink_idle", blink, 0);

        tick(2);
        checkOutput("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
